// File: rtl/sound_pkg.sv
// Shared audio-path definitions: recorder state encoding, sample/word widths
// and the sample-pair packing used by both the recorder and flash playback.
package sound_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_ACK   = 3'd2,
    ST_WRITE      = 3'd3,
    ST_DONE       = 3'd4
  } rec_state_t;

  // First sample of a pair lands in the low half, second in the high half.
  function automatic logic [WORD_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] lo,
                                                  input logic [SAMPLE_W-1:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/sound_recorder_if.sv
// Signal bundle between the recorder, the codec ADC FIFO and sample memory.
//
// Handshakes:
//   codec  : the FIFO offers a sample with read_ready; the recorder answers with
//            read_s held high until read_ready drops, and the pop is complete on
//            the edge that sees read_ready=0 while read_s=1.
//   avalon : mem_write/mem_address/mem_writedata are held stable while
//            mem_waitrequest=1; a word is accepted on the edge that sees
//            mem_write=1 and mem_waitrequest=0.
interface sound_recorder_if #(
  parameter int ADDR_W = 23
);
  import sound_pkg::*;

  logic                start;
  logic                pause;
  logic                read_ready;
  logic [SAMPLE_W-1:0] readdata_left;
  logic [SAMPLE_W-1:0] readdata_right;
  logic                read_s;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_address;
  logic [WORD_W-1:0]   mem_writedata;
  logic [3:0]          mem_byteenable;
  logic                mem_waitrequest;
  logic                busy;
  logic                done;

  modport master (
    input  start, pause, read_ready, readdata_left, readdata_right, mem_waitrequest,
    output read_s, mem_write, mem_address, mem_writedata, mem_byteenable, busy, done
  );

  modport slave (
    output start, pause, read_ready, readdata_left, readdata_right, mem_waitrequest,
    input  read_s, mem_write, mem_address, mem_writedata, mem_byteenable, busy, done
  );

endinterface

// File: rtl/sound_recorder_sample_pair_packer.sv
// Holds the sample being popped, the low half of the current pair and the
// half flag. Build option SOUND_REC_STEREO_AVG_EN averages left and right;
// without it only the left channel is recorded.
module sample_pair_packer
  import sound_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                clear,
  input  logic                capture,
  input  logic                commit,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                half,
  output logic [WORD_W-1:0]   pair_word
);

  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] low_q;
  logic                half_q;

`ifdef SOUND_REC_STEREO_AVG_EN
  // 17-bit signed sum, arithmetic shift right by one, keep 16 bits.
  logic signed [SAMPLE_W:0] sum;
  assign sum       = $signed({left[SAMPLE_W-1], left}) + $signed({right[SAMPLE_W-1], right});
  assign sample_in = sum[SAMPLE_W:1];
`else
  logic unused_right;
  assign sample_in    = left;
  assign unused_right = ^right;
`endif

  // Sample capture on pop start; pair bookkeeping on pop completion.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      low_q    <= '0;
      half_q   <= 1'b0;
    end else begin
      if (capture) sample_q <= sample_in;
      if (clear) begin
        half_q <= 1'b0;
      end else if (commit) begin
        if (!half_q) low_q <= sample_q;
        half_q <= ~half_q;
      end
    end
  end

  assign half      = half_q;
  assign pair_word = pack_pair(low_q, sample_q);

endmodule

// File: rtl/sound_recorder.sv
// Audio capture engine: pops codec samples, packs pairs into 32-bit words and
// writes them sequentially to sample memory over an Avalon-MM write master.
// Optional build macro: SOUND_REC_STEREO_AVG_EN (stereo averaging, see packer).
module sound_recorder
  import sound_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int NUM_WORDS = 1048576
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  sound_recorder_if.master         bus,
  output rec_state_t               state_dbg
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(NUM_WORDS);

  rec_state_t          state_q, state_n;
  logic                read_s_q, read_s_n;
  logic                mem_write_q, mem_write_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [WORD_W-1:0]   data_q, data_n;
  logic [ADDR_W:0]     count_q, count_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;

  logic                pk_clear;
  logic                pk_capture;
  logic                pk_commit;
  logic                pk_half;
  logic [WORD_W-1:0]   pk_word;

  sample_pair_packer u_packer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .clear     (pk_clear),
    .capture   (pk_capture),
    .commit    (pk_commit),
    .left      (bus.readdata_left),
    .right     (bus.readdata_right),
    .half      (pk_half),
    .pair_word (pk_word)
  );

  // State and output registers; reset drops mem_write without a clock edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      read_s_q    <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      read_s_q    <= read_s_n;
      mem_write_q <= mem_write_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      count_q     <= count_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

  // Next-state and next-output logic for the capture sequence.
  always_comb begin
    state_n     = state_q;
    read_s_n    = read_s_q;
    mem_write_n = mem_write_q;
    addr_n      = addr_q;
    data_n      = data_q;
    count_n     = count_q;
    pk_clear    = 1'b0;
    pk_capture  = 1'b0;
    pk_commit   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          addr_n   = '0;
          count_n  = '0;
          pk_clear = 1'b1;
          state_n  = ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        if (bus.read_ready && !bus.pause) begin
          pk_capture = 1'b1;
          read_s_n   = 1'b1;
          state_n    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.read_ready) begin
          read_s_n  = 1'b0;
          pk_commit = 1'b1;
          if (pk_half) begin
            data_n      = pk_word;
            mem_write_n = 1'b1;
            state_n     = ST_WRITE;
          end else begin
            state_n = ST_WAIT_READY;
          end
        end
      end
      ST_WRITE: begin
        if (!bus.mem_waitrequest) begin
          mem_write_n = 1'b0;
          addr_n      = addr_q + ADDR_W'(1);
          count_n     = count_q + (ADDR_W+1)'(1);
          // Stop after word NUM_WORDS-1; the address is left one past it.
          state_n     = (count_n == LAST_COUNT) ? ST_DONE : ST_WAIT_READY;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE) && (state_n != ST_DONE);
    done_n = (state_n == ST_DONE);
  end

  assign bus.read_s         = read_s_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_writedata  = data_q;
  assign bus.mem_byteenable = 4'hF;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_sound_recorder.sv
// Bench for sound_recorder: codec pop driver, Avalon accept monitor and a
// scoreboard of expected words/addresses built from the driven samples.
module tb_sound_recorder;
  import sound_pkg::*;

  localparam int ADDR_W    = 4;
  localparam int NUM_WORDS = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  rec_state_t state_dbg;

  sound_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  sound_recorder #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  int          next_addr = 0;
  logic        have_low = 1'b0;
  logic [15:0] low_exp = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sample(input logic [15:0] l, input logic [15:0] r);
    int s;
`ifdef SOUND_REC_STEREO_AVG_EN
    s = (int'($signed(l)) + int'($signed(r))) >>> 1;
`else
    s = int'($signed(l));
    if (r == 16'hDEAD) s = s;  // right channel has no effect
`endif
    return s[15:0];
  endfunction

  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] s;
    s = exp_sample(l, r);
    if (!have_low) begin
      low_exp  = s;
      have_low = 1'b1;
    end else begin
      exp_q.push_back({s, low_exp});
      exp_addr_q.push_back(32'(next_addr));
      next_addr++;
      have_low = 1'b0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_addr_q.delete();
    next_addr = 0;
    have_low  = 1'b0;
  endtask

  // Checks every accepted Avalon word against the scoreboard head.
  task automatic mem_monitor();
    logic [31:0] e_data, e_addr;
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (!reset && bus.mem_write && !bus.mem_waitrequest) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", 32'd1, 32'd0);
        end else begin
          e_data = exp_q.pop_front();
          e_addr = exp_addr_q.pop_front();
          check_val("wr_data", bus.mem_writedata, e_data);
          check_val("wr_addr", 32'(bus.mem_address), e_addr);
          check_val("wr_byteenable", 32'(bus.mem_byteenable), 32'hF);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge CLOCK_50);
    bus.start = 1'b1;
    model_clear();
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    check_val("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic pop_sample(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.read_ready     = 1'b1;
    model_push(l, r);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (bus.read_s) begin ok = 1; break; end
    end
    if (!ok) check_val("pop_rise_timeout", 32'd0, 32'd1);
    bus.read_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (!bus.read_s) begin ok = 1; break; end
    end
    if (!ok) check_val("pop_fall_timeout", 32'd0, 32'd1);
  endtask

  // Right channel equals left under averaging (result = left), random otherwise.
  task automatic pop_auto(input logic [15:0] l);
`ifdef SOUND_REC_STEREO_AVG_EN
    pop_sample(l, l);
`else
    pop_sample(l, 16'($urandom_range(0, 65535)));
`endif
  endtask

  task automatic wait_accepts(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (acc_cnt >= target) begin ok = 1; break; end
    end
    if (!ok) check_val("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.read_ready = 1'b0;
    bus.readdata_left = '0;
    bus.readdata_right = '0;
    bus.mem_waitrequest = 1'b0;
    fork
      mem_monitor();
    join_none

    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_val("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_val("rst_read_s", 32'(bus.read_s), 32'd0);
    check_val("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_val("rst_address", 32'(bus.mem_address), 32'd0);
    check_val("rst_writedata", bus.mem_writedata, 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_byteenable", 32'(bus.mem_byteenable), 32'hF);

    // Basic pair: 0x22221111 to address 0.
    pulse_start();
    pop_auto(16'h1111);
    pop_auto(16'h2222);
    wait_accepts(1);

    // Waitrequest stall for 5 cycles on the word at address 1.
    bus.mem_waitrequest = 1'b1;
    pop_auto(16'hAAAA);
    pop_auto(16'hBBBB);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!bus.mem_write || bus.mem_address != 4'd1 || bus.mem_writedata != 32'hBBBBAAAA) bad++;
      @(negedge CLOCK_50);
    end
    check_val("stall_stable_cycles_bad", 32'(bad), 32'd0);
    bus.mem_waitrequest = 1'b0;
    wait_accepts(2);
    repeat (5) @(negedge CLOCK_50);
    check_val("stall_single_accept", 32'(acc_cnt), 32'd2);

    // Pause in WAIT_READY with data offered for 20 cycles.
    bus.pause = 1'b1;
    bus.readdata_left = 16'h0C0C;
    bus.readdata_right = 16'h0C0C;
    bus.read_ready = 1'b1;
    model_push(16'h0C0C, 16'h0C0C);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (bus.read_s) bad++;
    end
    check_val("pause_read_s_high_cycles", 32'(bad), 32'd0);
    bus.pause = 1'b0;
    @(negedge CLOCK_50);
    check_val("pause_resume_read_s", 32'(bus.read_s), 32'd1);
    bus.read_ready = 1'b0;
    @(negedge CLOCK_50);
    check_val("pause_pop_done", 32'(bus.read_s), 32'd0);
    pop_auto(16'h0D0D);
    wait_accepts(3);
    pop_auto(16'h0E0E);
    pop_auto(16'h0F0F);
    wait_accepts(4);
    @(negedge CLOCK_50);
    check_val("first_rec_done", 32'(bus.done), 32'd1);
    check_val("first_rec_busy", 32'(bus.busy), 32'd0);

    // Full recording of samples 1..8, re-started from DONE.
    pulse_start();
    for (int s = 1; s <= 8; s++) pop_auto(16'(s));
    wait_accepts(8);
    @(negedge CLOCK_50);
    check_val("end_done", 32'(bus.done), 32'd1);
    check_val("end_busy", 32'(bus.busy), 32'd0);
    check_val("end_state", 32'(state_dbg), 32'(ST_DONE));
    check_val("end_address", 32'(bus.mem_address), 32'(NUM_WORDS % (1 << ADDR_W)));
    check_val("end_no_stray_write", 32'(bus.mem_write), 32'd0);

    // Reset while a write is stalled.
    pulse_start();
    bus.mem_waitrequest = 1'b1;
    pop_auto(16'h3333);
    pop_auto(16'h4444);
    check_val("mid_write_pending", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_reset_mem_write", 32'(bus.mem_write), 32'd0);
    check_val("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
    check_val("async_reset_busy", 32'(bus.busy), 32'd0);
    model_clear();
    @(negedge CLOCK_50);
    reset = 1'b0;
    bus.mem_waitrequest = 1'b0;
    pulse_start();
    pop_auto(16'h5555);
    pop_auto(16'h6666);
    wait_accepts(9);

    // Channel handling: averaging extremes, or right channel ignored.
`ifdef SOUND_REC_STEREO_AVG_EN
    pop_sample(16'h7FFF, 16'h7FFF);
    pop_sample(16'hFFFC, 16'h0002);
    check_val("avg_model_word", exp_q[0], 32'hFFFF7FFF);
`else
    pop_sample(16'h8001, 16'h7FFF);
    pop_sample(16'h0000, 16'hFFFF);
    check_val("left_only_model_word", exp_q[0], 32'h00008001);
`endif
    wait_accepts(10);

    repeat (3) @(negedge CLOCK_50);
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check_val("total_accepts", 32'(acc_cnt), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
